pc_gen: RTL and testbench



---
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential PC, prioritised redirects buffered across stalls, epoch tagging.
// Optional macro PC_GEN_MISALIGN_CHK_EN rejects misaligned redirect targets instead of clearing low bits.
module pc_gen #(
   parameter int                XLEN       = 64,
   parameter int                NUM_REDIR  = 3,
   parameter int                INST_BYTES = 4,
   parameter logic [XLEN-1:0]   RESET_PC   = 64'h8000_0000,
   parameter int                EPOCH_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REDIR-1:0]      redir_valid,
   input  logic [NUM_REDIR*XLEN-1:0] redir_target,
   input  logic                      fetch_ready,
   output logic                      fetch_valid,
   output logic [XLEN-1:0]           fetch_pc,
   output logic [EPOCH_W-1:0]        fetch_epoch,
   output logic [EPOCH_W-1:0]        cur_epoch,
`ifdef PC_GEN_MISALIGN_CHK_EN
   output logic                      misalign_valid,
   output logic [XLEN-1:0]           misalign_addr,
`endif
   output logic                      redir_pending
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);

   typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

   state_t             state, state_nxt;
   logic [XLEN-1:0]    pc_q, pc_nxt;
   logic [XLEN-1:0]    pend_q, pend_nxt;
   logic [XLEN-1:0]    raw_tgt, tgt;
   logic [EPOCH_W-1:0] epoch_nxt;
   logic               any_redir, take, fire, new_req;

   // Lowest index wins; losing channels are simply dropped.
   always_comb begin
      raw_tgt = '0;
      for (int i = NUM_REDIR - 1; i >= 0; i--)
         if (redir_valid[i]) raw_tgt = redir_target[i*XLEN +: XLEN];
   end

   assign any_redir = |redir_valid;
   assign tgt       = raw_tgt & ALIGN_MASK;

`ifdef PC_GEN_MISALIGN_CHK_EN
   logic misalign;
   assign misalign = any_redir && ((raw_tgt & ~ALIGN_MASK) != '0);
   assign take     = any_redir && !misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_valid <= 1'b0;
         misalign_addr  <= '0;
      end else begin
         misalign_valid <= misalign;
         if (misalign) misalign_addr <= raw_tgt;
      end
   end
`else
   assign take = any_redir;
`endif

   assign fetch_valid   = (state != BOOT);
   assign redir_pending = (state == PEND);
   assign fetch_pc      = pc_q;
   assign fire          = fetch_valid & fetch_ready;
   assign epoch_nxt     = cur_epoch + EPOCH_W'(take);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      pend_nxt  = pend_q;
      new_req   = 1'b0;
      case (state)
         BOOT: begin
            state_nxt = RUN;
            new_req   = 1'b1;
            if (take) pc_nxt = tgt;
         end
         RUN: begin
            if (fire) begin
               new_req = 1'b1;
               pc_nxt  = take ? tgt : pc_q + XLEN'(INST_BYTES);
            end else if (take) begin
               // Current request must stay stable; park the target until it is accepted.
               pend_nxt  = tgt;
               state_nxt = PEND;
            end
         end
         PEND: begin
            if (fire) begin
               new_req   = 1'b1;
               pc_nxt    = take ? tgt : pend_q;
               state_nxt = RUN;
            end else if (take) begin
               pend_nxt = tgt;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         pend_q      <= '0;
         cur_epoch   <= '0;
         fetch_epoch <= '0;
      end else begin
         pc_q      <= pc_nxt;
         pend_q    <= pend_nxt;
         cur_epoch <= epoch_nxt;
         if (new_req) fetch_epoch <= epoch_nxt;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus random checking of pc_gen (default build) against a behavioural fetch-PC model.
module tb_pc_gen;
   localparam int          XLEN = 64;
   localparam int          NR   = 3;
   localparam int          IB   = 4;
   localparam int          EW   = 2;
   localparam logic [63:0] RPC  = 64'h8000_0000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     redir_valid;
   logic [NR*XLEN-1:0] redir_target;
   logic              fetch_ready;
   logic              fetch_valid;
   logic [XLEN-1:0]   fetch_pc;
   logic [EW-1:0]     fetch_epoch;
   logic [EW-1:0]     cur_epoch;
   logic              redir_pending;

   pc_gen #(.XLEN(XLEN), .NUM_REDIR(NR), .INST_BYTES(IB), .RESET_PC(RPC), .EPOCH_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .redir_valid(redir_valid), .redir_target(redir_target),
      .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .fetch_epoch(fetch_epoch), .cur_epoch(cur_epoch), .redir_pending(redir_pending)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic          m_run;
   logic [63:0]   m_pc, m_pend;
   logic          m_pend_v;
   logic [EW-1:0] m_ep, m_fep;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 1'b0; m_pc = RPC; m_pend = '0; m_pend_v = 1'b0; m_ep = '0; m_fep = '0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 64'(fetch_valid), 64'(m_run));
      chk({tag, ".pc"}, fetch_pc, m_pc);
      chk({tag, ".fepoch"}, 64'(fetch_epoch), 64'(m_fep));
      chk({tag, ".cepoch"}, 64'(cur_epoch), 64'(m_ep));
      chk({tag, ".pending"}, 64'(redir_pending), 64'(m_pend_v));
   endtask

   task automatic model_edge(input logic [2:0] v, input logic [63:0] t0, t1, t2, input logic rdy);
      logic [63:0]   tgt;
      logic          any, fire;
      logic [EW-1:0] ep_new;
      any = (v != 3'b000);
      if (v[0])      tgt = t0;
      else if (v[1]) tgt = t1;
      else           tgt = t2;
      tgt    = tgt - (tgt % IB);
      fire   = m_run && rdy;
      ep_new = m_ep + (any ? 1 : 0);
      if (!m_run) begin
         if (any) m_pc = tgt;
         m_run = 1'b1;
         m_fep = ep_new;
      end else if (fire) begin
         if (any)           m_pc = tgt;
         else if (m_pend_v) m_pc = m_pend;
         else               m_pc = m_pc + IB;
         m_pend_v = 1'b0;
         m_fep    = ep_new;
      end else if (any) begin
         m_pend_v = 1'b1;
         m_pend   = tgt;
      end
      m_ep = ep_new;
   endtask

   task automatic step(input logic [2:0] v, input logic [63:0] t0, t1, t2, input logic rdy);
      redir_valid  = v;
      redir_target = {t2, t1, t0};
      fetch_ready  = rdy;
      @(negedge clk);
      check_all("step");
      @(posedge clk);
      model_edge(v, t0, t1, t2, rdy);
      #1;
   endtask

   initial begin
      logic [EW-1:0] e0;
      logic [2:0]    rv;
      redir_valid = '0; redir_target = '0; fetch_ready = 1'b0; rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Boot and sequential run
      step(3'b000, 0, 0, 0, 1'b1);
      chk("boot_valid", 64'(fetch_valid), 64'd1);
      chk("boot_pc", fetch_pc, 64'h8000_0000);
      step(3'b000, 0, 0, 0, 1'b1);
      chk("seq_pc1", fetch_pc, 64'h8000_0004);
      step(3'b000, 0, 0, 0, 1'b1);
      chk("seq_pc2", fetch_pc, 64'h8000_0008);
      step(3'b000, 0, 0, 0, 1'b1);
      step(3'b000, 0, 0, 0, 1'b1);
      chk("seq_pc4", fetch_pc, 64'h8000_0010);

      // Redirect during stall is buffered
      step(3'b010, 0, 64'h8000_1000, 0, 1'b0);
      chk("stall_pend", 64'(redir_pending), 64'd1);
      chk("stall_cep", 64'(cur_epoch), 64'd1);
      chk("stall_fep", 64'(fetch_epoch), 64'd0);
      step(3'b000, 0, 0, 0, 1'b0);
      step(3'b000, 0, 0, 0, 1'b0);
      chk("stall_pc", fetch_pc, 64'h8000_0010);
      step(3'b000, 0, 0, 0, 1'b1);
      chk("pend_pc", fetch_pc, 64'h8000_1000);
      chk("pend_fep", 64'(fetch_epoch), 64'd1);
      chk("pend_clr", 64'(redir_pending), 64'd0);

      // Simultaneous channels 0 and 2
      step(3'b101, 64'h8000_2000, 0, 64'h8000_3000, 1'b1);
      chk("prio_pc", fetch_pc, 64'h8000_2000);
      chk("prio_cep", 64'(cur_epoch), 64'd2);

      // Newest pending redirect wins
      e0 = m_ep;
      step(3'b010, 0, 64'h8000_5000, 0, 1'b0);
      step(3'b001, 64'h8000_4000, 0, 0, 1'b0);
      step(3'b000, 0, 0, 0, 1'b1);
      chk("newest_pc", fetch_pc, 64'h8000_4000);
      chk("newest_cep", 64'(cur_epoch), 64'(EW'(e0 + 2'd2)));

      // Address wrap
      step(3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1'b1);
      step(3'b000, 0, 0, 0, 1'b1);
      chk("wrap_pc", fetch_pc, 64'h0);

      // Misaligned target low bits cleared
      step(3'b001, 64'h8000_0002, 0, 0, 1'b1);
      chk("align_pc", fetch_pc, 64'h8000_0000);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         rv = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
         step(rv, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3) != 0);
      end

      // Asynchronous reset while pending
      step(3'b001, 64'h8000_7000, 0, 0, 1'b0);
      chk("pre_rst_pend", 64'(redir_pending), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(3'b000, 0, 0, 0, 1'b1);
      step(3'b000, 0, 0, 0, 1'b1);
      chk("post_rst_pc", fetch_pc, 64'h8000_0004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
